// File: rtl/osd_io_master.sv
// OSD overlay I/O master: frames a command word plus cmd_len data words onto
// the io_osd/io_strobe/io_din bus, with a programmable strobe gap and a
// programmable frame-close interval.
module osd_io_master #(
  parameter int unsigned GAP_CYCLES   = 2,  // strobe-low cycles after each pulse, 1..15
  parameter int unsigned CLOSE_CYCLES = 2   // io_osd-low cycles closing a frame, 2..15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_byte,
  input  logic [12:0] cmd_len,
  input  logic        dat_valid,
  output logic        dat_ready,
  input  logic [15:0] dat_word,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DWAIT  = 3'd4;
  localparam logic [2:0] S_CLOSE  = 3'd5;

  // Counters load N-1 on entry so the state lasts exactly N cycles.
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] CLOSE_LOAD = 4'(CLOSE_CYCLES - 1);

  logic [2:0]  state_q,     state_d;
  logic [12:0] remaining_q, remaining_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [15:0] io_din_q,    io_din_d;
  logic        io_osd_q,    io_osd_d;
  logic        io_strobe_q, io_strobe_d;
  logic        cmd_fire;
  logic        dat_fire;

  // Handshakes are gated by reset so nothing is consumed while reset is high.
  always_comb begin
    cmd_ready = (state_q == S_IDLE)  && !reset;
    dat_ready = (state_q == S_DWAIT) && !reset;
    busy      = (state_q != S_IDLE);
    cmd_fire  = cmd_valid && cmd_ready;
    dat_fire  = dat_valid && dat_ready;
  end

  // Next-state, counter and bus-word computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    io_din_d    = io_din_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          remaining_d = cmd_len;
          io_din_d    = {8'h00, cmd_byte};
          state_d     = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: begin
        cnt_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (remaining_q != 13'd0) begin
          state_d = S_DWAIT;
        end else begin
          cnt_d    = CLOSE_LOAD;
          io_din_d = 16'h0000;
          state_d  = S_CLOSE;
        end
      end
      S_DWAIT: begin
        // remaining is non-zero here, so the decrement cannot underflow.
        if (dat_fire) begin
          io_din_d    = dat_word;
          remaining_d = remaining_q - 13'd1;
          state_d     = S_SETUP;
        end
      end
      S_CLOSE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from the next state so they are glitch-free yet
    // line up exactly with the state they describe.
    io_osd_d    = (state_d == S_SETUP) || (state_d == S_STROBE) ||
                  (state_d == S_GAP)   || (state_d == S_DWAIT);
    io_strobe_d = (state_d == S_STROBE);
  end

  // State and output registers; reset aborts any frame with no CLOSE phase.
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 13'd0;
      cnt_q       <= 4'd0;
      io_din_q    <= 16'h0000;
      io_osd_q    <= 1'b0;
      io_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      io_din_q    <= io_din_d;
      io_osd_q    <= io_osd_d;
      io_strobe_q <= io_strobe_d;
    end
  end

  assign io_osd    = io_osd_q;
  assign io_strobe = io_strobe_q;
  assign io_din    = io_din_q;

endmodule
